mrd_bank_sched: RTL and testbench
=================================

// Module: mrd_bank_sched
// PURPOSE
//  N-bank frame scheduler for the mixed-radix DFT: generalises the 2-bank ping-pong ctrl/switch pair to NUM_BANKS banks.
//  Steers the sink stream into free banks round-robin and grants the single rdx2345 engine to one filled bank at a time.
//  Drains computed banks to the source in arrival order. Also checks frame framing and length against dftpts.
//  Sits between the top-level Avalon-ST sink and the mrd_mem_top bank array / switches.
// PARAMETERS
//  NUM_BANKS  2     number of frame banks (2..8)
//  PTS_W      12    width of dftpts
//  MAX_PTS    1200  largest legal DFT size; BANK_W=$clog2(NUM_BANKS), ADDR_W=$clog2(MAX_PTS)
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous reset, active-high
//  sink_valid    in   1       input beat valid
//  sink_ready    out  1       scheduler can accept a beat
//  sink_sop      in   1       first beat of frame
//  sink_eop      in   1       last beat of frame
//  sink_dftpts   in   PTS_W   frame size, sampled on the sop beat
//  sink_inverse  in   1       IDFT flag, sampled on the sop beat
//  wr_en         out  1       write the current beat into bank wr_bank
//  wr_bank       out  BANK_W  bank being filled (drives switch_in)
//  wr_addr       out  ADDR_W  sample index within frame
//  comp_start    out  1       1-cycle pulse: engine starts on comp_bank
//  comp_bank     out  BANK_W  bank owned by engine (drives rdx2345 switch)
//  comp_dftpts   out  PTS_W   size of frame in comp_bank
//  comp_inverse  out  1       inverse flag of frame in comp_bank
//  comp_done     in   1       1-cycle pulse: engine finished comp_bank
//  out_start     out  1       1-cycle pulse: bank out_bank begins draining
//  out_bank      out  BANK_W  bank routed to source (drives switch_out)
//  out_dftpts    out  PTS_W   size of frame being drained
//  out_done      in   1       1-cycle pulse: drain of out_bank finished (eop sent)
//  err_len       out  1       1-cycle pulse: eop beat count != dftpts
//  err_frame     out  1       1-cycle pulse: beat without sop, sop inside frame, or illegal dftpts
//  busy          out  1       any bank not FREE
// BEHAVIOUR
//  Reset: all banks FREE; wr/comp/out pointers=0; all outputs 0 except sink_ready=1 (bank 0 FREE).
//  Per-bank state: FREE->FILL->READY->COMP->DONE->DRAIN->FREE; states, dftpts and inverse are stored per bank.
//  Three round-robin pointers wr_ptr, comp_ptr and out_ptr advance modulo NUM_BANKS. This preserves frame order end to end.
//  sink_ready = state[wr_ptr] in {FREE,FILL}. A beat is accepted when sink_valid&sink_ready.
//  FREE + accepted sop beat:
//   - legal dftpts (1..MAX_PTS): latch dftpts/inverse, go FILL, wr_en=1, wr_addr=0.
//   - sop&eop on the same beat: go straight to READY.
//  FREE + accepted beat without sop: drop the beat (wr_en=0), pulse err_frame, stay FREE.
//  FILL + accepted beat: wr_en=1, wr_addr=beat count (increments per accepted beat, never past MAX_PTS-1).
//   - eop: bank->READY, wr_ptr++.
//   - eop with count+1 != dftpts: pulse err_len; the frame is still committed.
//   - sop inside FILL: pulse err_frame, restart the frame in the same bank (count=0, relatch dftpts).
//  Illegal dftpts (0 or >MAX_PTS) on sop: pulse err_frame, drop beats with wr_en=0 until eop, bank stays FREE.
//  wr_en, wr_bank and wr_addr are combinational from the accepting beat (0-cycle latency to the bank write port).
//  Engine FSM: E_IDLE / E_RUN.
//   - E_IDLE with state[comp_ptr]==READY: next cycle comp_start=1, bank->COMP, go E_RUN.
//   - E_RUN + comp_done: bank->DONE, comp_ptr++, go E_IDLE. The next comp_start may follow no earlier than the cycle after comp_done.
//  comp_done while E_IDLE is ignored.
//  Drain FSM: O_IDLE / O_RUN, same pattern on state[out_ptr]==DONE.
//   - Entry: out_start pulse, bank->DRAIN.
//   - out_done: bank->FREE, out_ptr++.
//  comp_bank/out_bank are registered and held stable while RUN. comp_dftpts/out_dftpts come from per-bank registers.
//  Simultaneous events in one cycle are all honoured: eop on bank i, comp_done on j, out_done on k (i,j,k distinct by construction).
//  Full: every bank non-FREE/FILL -> sink_ready=0 until the next out_done frees wr_ptr's bank (sink_ready=1 the cycle after).
//  rst mid-operation: all state returns to reset values immediately; partial frames are discarded; no done pulses are expected.
// TESTING
//  1. NUM_BANKS=2, one 12-pt frame -> wr_addr 0..11, comp_start 1 cycle after eop, out_start 1 cycle after comp_done, busy=0 after out_done.
//  2. NUM_BANKS=3, 4 back-to-back 60-pt frames, engine slow (comp_done 200 cycles) -> sink_ready=0 after frame 3; frame 4 lands in bank 0; out order 0,1,2,0.
//  3. sop dftpts=24 but eop on beat 20 -> err_len pulse at eop; frame still computed with comp_dftpts=24.
//  4. Beat without sop while FREE -> err_frame, wr_en=0; sop mid-frame at beat 5 -> err_frame, wr_addr restarts at 0.
//  5. dftpts=0 and dftpts=1201 -> err_frame, no comp_start, bank stays FREE.
//  6. Assert rst during COMP with 2 banks full -> next cycle sink_ready=1, wr_bank=0, busy=0, no pulses.

Source files
------------

// File: rtl/mrd_bank_sched.sv
// N-bank frame scheduler for the mixed-radix DFT.
// Fills free banks round-robin from the sink stream, hands filled banks to the single
// engine in order, then drains computed banks to the source in the same order.
module mrd_bank_sched #(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned PTS_W     = 12,
    parameter int unsigned MAX_PTS   = 1200,
    localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned ADDR_W   = $clog2(MAX_PTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [PTS_W-1:0]  sink_dftpts,
    input  logic              sink_inverse,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              comp_start,
    output logic [BANK_W-1:0] comp_bank,
    output logic [PTS_W-1:0]  comp_dftpts,
    output logic              comp_inverse,
    input  logic              comp_done,
    output logic              out_start,
    output logic [BANK_W-1:0] out_bank,
    output logic [PTS_W-1:0]  out_dftpts,
    input  logic              out_done,
    output logic              err_len,
    output logic              err_frame,
    output logic              busy
);

    typedef enum logic [2:0] {BkFree, BkFill, BkReady, BkComp, BkDone, BkDrain} bank_st_e;
    typedef enum logic {EngIdle, EngRun} eng_st_e;
    typedef enum logic {DrnIdle, DrnRun} drn_st_e;

    localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_PTS - 1);

    bank_st_e          bank_st_q [NUM_BANKS];
    bank_st_e          bank_st_d [NUM_BANKS];
    logic [PTS_W-1:0]  pts_q     [NUM_BANKS];
    logic [PTS_W-1:0]  pts_d     [NUM_BANKS];
    logic              inv_q     [NUM_BANKS];
    logic              inv_d     [NUM_BANKS];
    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0] comp_ptr_q, comp_ptr_d;
    logic [BANK_W-1:0] out_ptr_q, out_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // A beat has already been written at the last address of the bank.
    logic              ovf_q, ovf_d;
    // Discarding the remainder of a frame whose sop carried an illegal size.
    logic              drop_q, drop_d;
    eng_st_e           eng_q, eng_d;
    drn_st_e           drn_q, drn_d;

    bank_st_e          wr_st;
    logic              accept;
    logic              pts_legal;

    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == LastBank) ? '0 : p + BANK_W'(1);
    endfunction

    assign wr_st        = bank_st_q[wr_ptr_q];
    assign sink_ready   = (wr_st == BkFree) || (wr_st == BkFill);
    assign accept       = sink_valid & sink_ready;
    assign pts_legal    = (sink_dftpts != '0) && (32'(sink_dftpts) <= MAX_PTS);
    assign wr_bank      = wr_ptr_q;
    assign comp_bank    = comp_ptr_q;
    assign comp_dftpts  = pts_q[comp_ptr_q];
    assign comp_inverse = inv_q[comp_ptr_q];
    assign out_bank     = out_ptr_q;
    assign out_dftpts   = pts_q[out_ptr_q];

    // Next-state for banks, pointers and both FSMs; the three agents touch distinct banks.
    always_comb begin
        bank_st_d  = bank_st_q;
        pts_d      = pts_q;
        inv_d      = inv_q;
        wr_ptr_d   = wr_ptr_q;
        comp_ptr_d = comp_ptr_q;
        out_ptr_d  = out_ptr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        eng_d      = eng_q;
        drn_d      = drn_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        err_len    = 1'b0;
        err_frame  = 1'b0;
        comp_start = 1'b0;
        out_start  = 1'b0;

        // Write side
        if (accept) begin
            if (sink_sop) begin
                if (pts_legal) begin
                    wr_en            = 1'b1;
                    err_frame        = (wr_st == BkFill);
                    pts_d[wr_ptr_q]  = sink_dftpts;
                    inv_d[wr_ptr_q]  = sink_inverse;
                    cnt_d            = ADDR_W'(1);
                    ovf_d            = 1'b0;
                    drop_d           = 1'b0;
                    if (sink_eop) begin
                        bank_st_d[wr_ptr_q] = BkReady;
                        wr_ptr_d            = ptr_inc(wr_ptr_q);
                        err_len             = (sink_dftpts != PTS_W'(1));
                    end else begin
                        bank_st_d[wr_ptr_q] = BkFill;
                    end
                end else begin
                    // Abandon any open frame and swallow beats up to its eop.
                    err_frame           = 1'b1;
                    bank_st_d[wr_ptr_q] = BkFree;
                    drop_d              = ~sink_eop;
                end
            end else if (wr_st == BkFill) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == LastAddr) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
                if (sink_eop) begin
                    bank_st_d[wr_ptr_q] = BkReady;
                    wr_ptr_d            = ptr_inc(wr_ptr_q);
                    err_len = ovf_q || ((32'(cnt_q) + 32'd1) != 32'(pts_q[wr_ptr_q]));
                end
            end else if (drop_q) begin
                if (sink_eop) begin
                    drop_d = 1'b0;
                end
            end else begin
                err_frame = 1'b1;
            end
        end

        // Engine side; comp_done while idle is ignored
        unique case (eng_q)
            EngIdle: begin
                if (bank_st_q[comp_ptr_q] == BkReady) begin
                    comp_start            = 1'b1;
                    bank_st_d[comp_ptr_q] = BkComp;
                    eng_d                 = EngRun;
                end
            end
            EngRun: begin
                if (comp_done) begin
                    bank_st_d[comp_ptr_q] = BkDone;
                    comp_ptr_d            = ptr_inc(comp_ptr_q);
                    eng_d                 = EngIdle;
                end
            end
        endcase

        // Drain side
        unique case (drn_q)
            DrnIdle: begin
                if (bank_st_q[out_ptr_q] == BkDone) begin
                    out_start            = 1'b1;
                    bank_st_d[out_ptr_q] = BkDrain;
                    drn_d                = DrnRun;
                end
            end
            DrnRun: begin
                if (out_done) begin
                    bank_st_d[out_ptr_q] = BkFree;
                    out_ptr_d            = ptr_inc(out_ptr_q);
                    drn_d                = DrnIdle;
                end
            end
        endcase
    end

    // Busy whenever any bank holds or is collecting a frame.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_st_q[i] != BkFree) begin
                busy = 1'b1;
            end
        end
    end

    // State registers; reset discards everything including partial frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_st_q[i] <= BkFree;
                pts_q[i]     <= '0;
                inv_q[i]     <= 1'b0;
            end
            wr_ptr_q   <= '0;
            comp_ptr_q <= '0;
            out_ptr_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            eng_q      <= EngIdle;
            drn_q      <= DrnIdle;
        end else begin
            bank_st_q  <= bank_st_d;
            pts_q      <= pts_d;
            inv_q      <= inv_d;
            wr_ptr_q   <= wr_ptr_d;
            comp_ptr_q <= comp_ptr_d;
            out_ptr_q  <= out_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            eng_q      <= eng_d;
            drn_q      <= drn_d;
        end
    end

endmodule

// File: tb/tb_mrd_bank_sched.sv
// Bench for mrd_bank_sched: frame-level reference model (counts of committed, computed
// and drained frames) driven cycle by cycle, with directed and random frames.
module tb_mrd_bank_sched;

    localparam int NB      = 3;
    localparam int PTS_W   = 12;
    localparam int MAX_PTS = 1200;
    localparam int BANK_W  = 2;
    localparam int ADDR_W  = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, sink_inverse = 1'b0;
    logic [PTS_W-1:0]  sink_dftpts = '0;
    logic              sink_ready, wr_en, comp_start, comp_inverse, out_start;
    logic [BANK_W-1:0] wr_bank, comp_bank, out_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [PTS_W-1:0]  comp_dftpts, out_dftpts;
    logic              comp_done = 1'b0, out_done = 1'b0;
    logic              err_len, err_frame, busy;

    mrd_bank_sched #(.NUM_BANKS(NB), .PTS_W(PTS_W), .MAX_PTS(MAX_PTS)) dut (
        .clk(clk), .rst(rst),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_dftpts(sink_dftpts), .sink_inverse(sink_inverse),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .comp_start(comp_start), .comp_bank(comp_bank), .comp_dftpts(comp_dftpts),
        .comp_inverse(comp_inverse), .comp_done(comp_done),
        .out_start(out_start), .out_bank(out_bank), .out_dftpts(out_dftpts),
        .out_done(out_done), .err_len(err_len), .err_frame(err_frame), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frames are numbered in commit order; frame k lives in bank k % NB.
    int m_commit, m_cfin, m_freed;
    bit m_eng_run, m_drn_run;
    int m_ccd, m_ocd;
    bit m_open, m_drop;
    int m_cnt, m_pts;
    bit m_inv;
    int fr_pts [1024];
    bit fr_inv [1024];
    bit m_acc;
    bit gaps = 1'b0, spur_en = 1'b0;
    int c_lo = 0, c_hi = 0, o_lo = 0, o_hi = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_commit = 0; m_cfin = 0; m_freed = 0;
        m_eng_run = 0; m_drn_run = 0; m_ccd = 0; m_ocd = 0;
        m_open = 0; m_drop = 0; m_cnt = 0; m_pts = 0; m_inv = 0; m_acc = 0;
    endtask

    // One clock cycle: sink inputs are already set by the caller.
    task automatic tick();
        bit spur, exp_rdy, acc, e_wen, e_elen, e_efr, e_cs, e_os, e_busy, do_commit;
        int e_addr, e_bank;
        spur      = spur_en && ($urandom_range(3, 0) == 0);
        comp_done = (m_eng_run && m_ccd == 0) || (!m_eng_run && spur);
        out_done  = (m_drn_run && m_ocd == 0) || (!m_drn_run && spur);
        #1;
        exp_rdy = (m_commit - m_freed) < NB;
        acc     = sink_valid && exp_rdy;
        e_cs    = !m_eng_run && (m_cfin < m_commit);
        e_os    = !m_drn_run && (m_freed < m_cfin);
        e_busy  = (m_commit != m_freed) || m_open;
        e_bank  = m_commit % NB;
        e_wen = 0; e_addr = 0; e_elen = 0; e_efr = 0; do_commit = 0;
        if (acc) begin
            if (sink_sop) begin
                if (sink_dftpts >= 1 && sink_dftpts <= MAX_PTS) begin
                    e_wen = 1; e_efr = m_open; m_drop = 0;
                    m_pts = int'(sink_dftpts); m_inv = sink_inverse;
                    if (sink_eop) begin
                        e_elen = (m_pts != 1); do_commit = 1; m_open = 0;
                    end else begin
                        m_open = 1; m_cnt = 1;
                    end
                end else begin
                    e_efr = 1; m_open = 0; m_drop = !sink_eop;
                end
            end else if (m_open) begin
                e_wen  = 1;
                e_addr = (m_cnt < MAX_PTS) ? m_cnt : MAX_PTS - 1;
                m_cnt++;
                if (sink_eop) begin
                    e_elen = (m_cnt != m_pts); do_commit = 1; m_open = 0;
                end
            end else if (m_drop) begin
                if (sink_eop) m_drop = 0;
            end else begin
                e_efr = 1;
            end
        end

        chk("sink_ready", sink_ready, exp_rdy);
        chk("wr_en", wr_en, e_wen);
        if (e_wen) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_bank", wr_bank, e_bank);
        end
        chk("err_len", err_len, e_elen);
        chk("err_frame", err_frame, e_efr);
        chk("comp_start", comp_start, e_cs);
        chk("out_start", out_start, e_os);
        chk("busy", busy, e_busy);
        chk("comp_bank", comp_bank, m_cfin % NB);
        chk("out_bank", out_bank, m_freed % NB);
        if (e_cs || m_eng_run) begin
            chk("comp_dftpts", comp_dftpts, fr_pts[m_cfin % 1024]);
            chk("comp_inverse", comp_inverse, fr_inv[m_cfin % 1024]);
        end
        if (e_os || m_drn_run) chk("out_dftpts", out_dftpts, fr_pts[m_freed % 1024]);

        if (do_commit) begin
            fr_pts[m_commit % 1024] = m_pts;
            fr_inv[m_commit % 1024] = m_inv;
            m_commit++;
        end
        if (e_cs) begin
            m_eng_run = 1; m_ccd = $urandom_range(c_hi, c_lo);
        end else if (m_eng_run) begin
            if (comp_done) begin m_eng_run = 0; m_cfin++; end
            else m_ccd--;
        end
        if (e_os) begin
            m_drn_run = 1; m_ocd = $urandom_range(o_hi, o_lo);
        end else if (m_drn_run) begin
            if (out_done) begin m_drn_run = 0; m_freed++; end
            else m_ocd--;
        end
        m_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one beat until the model says it was accepted (bounded).
    task automatic beat(input bit sop, input bit eop, input int pts, input bit inv);
        if (gaps && $urandom_range(3, 0) == 0) tick();
        sink_valid = 1; sink_sop = sop; sink_eop = eop;
        sink_dftpts = PTS_W'(pts); sink_inverse = inv;
        m_acc = 0;
        for (int w = 0; w < 4000 && !m_acc; w++) tick();
        if (!m_acc) chk("beat_accept_timeout", m_acc, 1);
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
    endtask

    task automatic send_frame(input int pts, input int beats, input bit inv);
        for (int i = 0; i < beats; i++) beat(i == 0, i == beats - 1, pts, inv);
    endtask

    task automatic flush();
        for (int w = 0; w < 20000 && m_commit != m_freed; w++) tick();
        if (m_commit != m_freed) chk("flush_timeout", m_commit - m_freed, 0);
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1; sink_valid = 0; sink_sop = 0; sink_eop = 0;
        comp_done = 0; out_done = 0;
        #1;
        chk("rst_sink_ready", sink_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_comp_start", comp_start, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_err", {err_len, err_frame}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_wr_bank", wr_bank, 0);
        chk("post_rst_comp_bank", comp_bank, 0);
    endtask

    initial begin
        int kind, pts;
        bit inv;
        model_reset();
        do_reset();

        // Single short frame, quick engine and drain
        c_lo = 3; c_hi = 3; o_lo = 5; o_hi = 5;
        send_frame(12, 12, 1);
        flush();

        // Back-to-back 60-pt frames against a slow engine: bank fills up, frame 4 wraps
        c_lo = 200; c_hi = 200; o_lo = 10; o_hi = 10;
        for (int f = 0; f < 4; f++) send_frame(60, 60, f[0]);
        flush();

        // Short frame: err_len at eop, still computed with the sop size
        c_lo = 2; c_hi = 6; o_lo = 2; o_hi = 6;
        send_frame(24, 20, 0);
        send_frame(5, 7, 1);
        flush();

        // Stray beat while free, then sop restart inside a frame
        beat(0, 0, 8, 0);
        for (int i = 0; i < 5; i++) beat(i == 0, 0, 16, 0);
        send_frame(16, 16, 1);
        flush();

        // Illegal sizes are dropped entirely
        send_frame(0, 4, 0);
        send_frame(1201, 3, 1);
        send_frame(4095, 1, 0);
        send_frame(1, 1, 1);
        flush();

        // Largest size exact, then overlong (address saturates, err_len)
        gaps = 0;
        send_frame(MAX_PTS, MAX_PTS, 0);
        send_frame(MAX_PTS, MAX_PTS + 2, 1);
        flush();

        // Spurious done pulses while idle are ignored
        spur_en = 1;
        idle(12);
        send_frame(3, 3, 0);
        flush();
        spur_en = 0;

        // Reset with two banks full and the engine busy
        c_lo = 200; c_hi = 200;
        send_frame(8, 8, 0);
        send_frame(9, 9, 1);
        idle(20);
        do_reset();
        idle(10);

        // Random traffic
        gaps = 1; c_lo = 0; c_hi = 30; o_lo = 0; o_hi = 30;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(9, 0);
            pts  = $urandom_range(40, 1);
            inv  = 1'($urandom_range(1, 0));
            if (kind == 0) send_frame(pts, pts + $urandom_range(3, 1), inv);
            else if (kind == 1 && pts > 1) send_frame(pts, pts - 1, inv);
            else if (kind == 2) send_frame((pts > 20) ? 0 : 1201 + pts, $urandom_range(4, 1), inv);
            else if (kind == 3) beat(0, 1'($urandom_range(1, 0)), pts, inv);
            else send_frame(pts, pts, inv);
            if ($urandom_range(3, 0) == 0) idle($urandom_range(20, 1));
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
